// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller: one-hot state encoding
// and the coin codes presented on coin_in.
package vend_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_COLLECT = 4'b0010,
        ST_VEND    = 4'b0100,
        ST_CHANGE  = 4'b1000
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'd0;
    localparam logic [1:0] COIN_1    = 2'd1;
    localparam logic [1:0] COIN_2    = 2'd2;
    localparam logic [1:0] COIN_3    = 2'd3;

endpackage

// File: rtl/vend_ctrl.sv
// Vending machine controller: accumulates coin credit, pulses vend when the
// price is reached, then pays back any remaining credit one unit at a time
// over a valid/ready change interface. All outputs are registered.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE    = 3,
    parameter int VAL1     = 1,
    parameter int VAL2     = 2,
    parameter int VAL3     = 5,
    parameter int CREDIT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          coin_in,
    input  logic                cancel,
    input  logic                chg_rdy,
    output logic                vend,
    output logic                chg_vld,
    output logic                coin_rej,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    localparam int SUM_W = CREDIT_W + 1;
    localparam int MAX_VAL = (VAL1 > VAL2) ? ((VAL1 > VAL3) ? VAL1 : VAL3)
                                           : ((VAL2 > VAL3) ? VAL2 : VAL3);
    localparam logic [SUM_W-1:0] PRICE_W = SUM_W'(PRICE);

    // Largest reachable sum is (PRICE-1) + MAX_VAL; it must fit in credit.
    if (PRICE < 1 || (2 ** CREDIT_W) <= (PRICE + MAX_VAL - 1)) begin : g_param_err
        $fatal(1, "vend_ctrl: PRICE/VALx do not fit in CREDIT_W bits");
    end

    // Unit value of a coin code, zero for "no coin".
    function automatic logic [SUM_W-1:0] coin_value(input logic [1:0] code);
        logic [SUM_W-1:0] v;
        case (code)
            COIN_1:  v = SUM_W'(VAL1);
            COIN_2:  v = SUM_W'(VAL2);
            COIN_3:  v = SUM_W'(VAL3);
            default: v = '0;
        endcase
        return v;
    endfunction

    state_t           state;
    logic [SUM_W-1:0] sum;
    logic             coin_seen;

    // Candidate credit after adding this cycle's coin, one bit wider so the
    // comparison against PRICE can never wrap.
    always_comb begin
        sum       = {1'b0, credit} + coin_value(coin_in);
        coin_seen = (coin_in != COIN_NONE);
    end

    // Controller state machine with all outputs registered alongside state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            credit   <= '0;
            vend     <= 1'b0;
            chg_vld  <= 1'b0;
            coin_rej <= 1'b0;
            busy     <= 1'b0;
        end else begin
            vend     <= 1'b0;
            coin_rej <= 1'b0;
            case (state)
                ST_IDLE, ST_COLLECT: begin
                    if (coin_seen) begin
                        if (cancel) begin
                            // Coin plus cancel: refund everything, never vend.
                            credit  <= CREDIT_W'(sum);
                            state   <= ST_CHANGE;
                            chg_vld <= 1'b1;
                            busy    <= 1'b1;
                        end else if (sum >= PRICE_W) begin
                            credit <= CREDIT_W'(sum - PRICE_W);
                            state  <= ST_VEND;
                            vend   <= 1'b1;
                            busy   <= 1'b1;
                        end else begin
                            credit <= CREDIT_W'(sum);
                            state  <= ST_COLLECT;
                        end
                    end else if (cancel && state == ST_COLLECT) begin
                        state   <= ST_CHANGE;
                        chg_vld <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                ST_VEND: begin
                    coin_rej <= coin_seen;
                    if (credit != '0) begin
                        state   <= ST_CHANGE;
                        chg_vld <= 1'b1;
                        busy    <= 1'b1;
                    end else begin
                        state   <= ST_IDLE;
                        chg_vld <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                ST_CHANGE: begin
                    coin_rej <= coin_seen;
                    if (credit == '0) begin
                        state   <= ST_IDLE;
                        chg_vld <= 1'b0;
                        busy    <= 1'b0;
                    end else if (chg_vld && chg_rdy) begin
                        credit <= credit - CREDIT_W'(1);
                        if (credit == CREDIT_W'(1)) begin
                            state   <= ST_IDLE;
                            chg_vld <= 1'b0;
                            busy    <= 1'b0;
                        end
                    end
                end
                default: begin
                    // Corrupted encoding: fall back to a clean idle machine.
                    state   <= ST_IDLE;
                    credit  <= '0;
                    chg_vld <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_ctrl.sv
// Scoreboard bench for vend_ctrl (PRICE=3, coin values 1/2/5). Each stimulus
// step pushes the output record it should produce; a forked monitor pops and
// compares whenever the DUT shows vend, chg_vld or coin_rej.
module tb_vend_ctrl;

    typedef struct packed {
        logic       vend;
        logic       chg_vld;
        logic       coin_rej;
        logic [3:0] credit;
        logic       busy;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] coin_in = 2'd0;
    logic       cancel = 1'b0;
    logic       chg_rdy = 1'b0;
    logic       vend;
    logic       chg_vld;
    logic       coin_rej;
    logic       busy;
    logic [3:0] credit;

    int   n_tests = 0;
    int   n_fail  = 0;
    rec_t exp_q[$];

    vend_ctrl #(
        .PRICE(3), .VAL1(1), .VAL2(2), .VAL3(5), .CREDIT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .coin_in(coin_in), .cancel(cancel),
        .chg_rdy(chg_rdy), .vend(vend), .chg_vld(chg_vld),
        .coin_rej(coin_rej), .busy(busy), .credit(credit)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s got=%0d required=%0d", name, got, want);
        end
    endtask

    // Apply one cycle of inputs; returns just after the sampling edge.
    task automatic step(input logic [1:0] c, input logic can, input logic rdy);
        coin_in = c;
        cancel  = can;
        chg_rdy = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rec(input logic v, input logic cv, input logic rj,
                              input int cr, input logic b);
        rec_t r;
        r.vend     = v;
        r.chg_vld  = cv;
        r.coin_rej = rj;
        r.credit   = 4'(cr);
        r.busy     = b;
        exp_q.push_back(r);
    endtask

    task automatic monitor();
        rec_t got;
        rec_t want;
        forever begin
            @(negedge clk);
            if (!rst && (vend || chg_vld || coin_rej)) begin
                got = {vend, chg_vld, coin_rej, credit, busy};
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output got v=%0b cv=%0b rej=%0b cr=%0d busy=%0b required no output",
                             got.vend, got.chg_vld, got.coin_rej, got.credit, got.busy);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        n_fail++;
                        $display("FAIL output_record got v=%0b cv=%0b rej=%0b cr=%0d busy=%0b required v=%0b cv=%0b rej=%0b cr=%0d busy=%0b",
                                 got.vend, got.chg_vld, got.coin_rej, got.credit, got.busy,
                                 want.vend, want.chg_vld, want.coin_rej, want.credit, want.busy);
                    end
                end
            end
        end
    endtask

    // Wait (bounded) for every expected record to be consumed, then confirm idle.
    task automatic finish_scn(input string name);
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        check({name, "_queue_left"}, exp_q.size(), 0);
        exp_q.delete();
        coin_in = 2'd0;
        cancel  = 1'b0;
        chg_rdy = 1'b0;
        @(negedge clk);
        check({name, "_idle_credit"}, int'(credit), 0);
        check({name, "_idle_busy"}, int'(busy), 0);
        check({name, "_idle_chg_vld"}, int'(chg_vld), 0);
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reset state
        #2;
        check("rst_credit", int'(credit), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_vend", int'(vend), 0);
        check("rst_chg_vld", int'(chg_vld), 0);
        check("rst_coin_rej", int'(coin_rej), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Coins 1,1,1: vend after third coin, no change
        step(2'd1, 1'b0, 1'b0);
        step(2'd1, 1'b0, 1'b0);
        step(2'd1, 1'b0, 1'b0); expect_rec(1, 0, 0, 0, 1);
        step(2'd0, 1'b0, 1'b0);
        finish_scn("c111");

        // Coin 2, coin 2 with ready: vend then one change unit
        step(2'd2, 1'b0, 1'b1);
        step(2'd2, 1'b0, 1'b1); expect_rec(1, 0, 0, 1, 1);
        step(2'd0, 1'b0, 1'b1); expect_rec(0, 1, 0, 1, 1);
        step(2'd0, 1'b0, 1'b1);
        finish_scn("c22");

        // Coin 3 (value 5): change held at 2 through a 3-cycle stall
        step(2'd3, 1'b0, 1'b0); expect_rec(1, 0, 0, 2, 1);
        step(2'd0, 1'b0, 1'b0); expect_rec(0, 1, 0, 2, 1);
        step(2'd0, 1'b0, 1'b0); expect_rec(0, 1, 0, 2, 1);
        step(2'd0, 1'b0, 1'b0); expect_rec(0, 1, 0, 2, 1);
        step(2'd0, 1'b0, 1'b0); expect_rec(0, 1, 0, 2, 1);
        step(2'd0, 1'b0, 1'b1); expect_rec(0, 1, 0, 1, 1);
        step(2'd0, 1'b0, 1'b1);
        finish_scn("c3stall");

        // Coin 2 then coin 3: sum 7, vend, four units of change
        step(2'd2, 1'b0, 1'b1);
        step(2'd3, 1'b0, 1'b1); expect_rec(1, 0, 0, 4, 1);
        step(2'd0, 1'b0, 1'b1); expect_rec(0, 1, 0, 4, 1);
        step(2'd0, 1'b0, 1'b1); expect_rec(0, 1, 0, 3, 1);
        step(2'd0, 1'b0, 1'b1); expect_rec(0, 1, 0, 2, 1);
        step(2'd0, 1'b0, 1'b1); expect_rec(0, 1, 0, 1, 1);
        step(2'd0, 1'b0, 1'b1);
        finish_scn("c23max");

        // Coin 1 then cancel: one unit refunded, no vend
        step(2'd1, 1'b0, 1'b0);
        step(2'd0, 1'b1, 1'b1); expect_rec(0, 1, 0, 1, 1);
        step(2'd0, 1'b0, 1'b1);
        finish_scn("cancel1");

        // Coin 2 with cancel from IDLE: two units refunded, no vend
        step(2'd2, 1'b1, 1'b1); expect_rec(0, 1, 0, 2, 1);
        step(2'd0, 1'b0, 1'b1); expect_rec(0, 1, 0, 1, 1);
        step(2'd0, 1'b0, 1'b1);
        finish_scn("coincancel");

        // Cancel alone in IDLE is ignored
        step(2'd0, 1'b1, 1'b0);
        step(2'd0, 1'b0, 1'b0);
        finish_scn("cancelidle");

        // Coins while busy are rejected; then reset mid-CHANGE
        step(2'd3, 1'b0, 1'b0); expect_rec(1, 0, 0, 2, 1);
        step(2'd1, 1'b0, 1'b0); expect_rec(0, 1, 1, 2, 1);
        step(2'd1, 1'b1, 1'b0); expect_rec(0, 1, 1, 2, 1);
        coin_in = 2'd0;
        cancel  = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_chg_vld", int'(chg_vld), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_credit", int'(credit), 0);
        check("midrst_coin_rej", int'(coin_rej), 0);
        check("midrst_queue", exp_q.size(), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // First edge after reset release samples the coin
        step(2'd1, 1'b0, 1'b0);
        @(negedge clk);
        check("post_rst_credit", int'(credit), 1);
        check("post_rst_busy", int'(busy), 0);
        step(2'd0, 1'b1, 1'b1); expect_rec(0, 1, 0, 1, 1);
        step(2'd0, 1'b0, 1'b1);
        finish_scn("postrst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
